// File: rtl/branch_sequencer.sv
// Moore control-step sequencer for the Mini SRC datapath: fetch, decode,
// and full sequencing of br / jr / jal / nop / halt. All other opcodes are
// handed to the ALU/memory sequencers through exec_req/exec_done.
//
// state     | meaning
// ----------+--------------------------------------------------------
// T0        | PC to MAR, PC+1 into Z; stop sampled here
// T1        | Z to PC, memory read into MDR; held until mem_ready
// T2        | MDR to IR
// DEC       | IR valid, branch on opcode
// BR3..BR6  | conditional branch: CON capture, PC+C into Z, gated PCin
// JR3       | Ra to PC
// JAL3/JAL4 | incremented PC to R15, then Ra to PC
// EXEC_WAIT | delegated sequencer owns the datapath
// HALT      | stopped, only reset exits
module branch_sequencer #(
  parameter logic [4:0] OP_BR   = 5'b10010,
  parameter logic [4:0] OP_JR   = 5'b10011,
  parameter logic [4:0] OP_JAL  = 5'b10100,
  parameter logic [4:0] OP_NOP  = 5'b11001,
  parameter logic [4:0] OP_HALT = 5'b11010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        mem_ready,
  input  logic        exec_done,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        Rout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        CONin,
  output logic        LinkIn,
  output logic        IncPC,
  output logic        ADD,
  output logic        Read,
  output logic        Gra,
  output logic        exec_req,
  output logic        run,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_T0        = 4'd0,
    S_T1        = 4'd1,
    S_T2        = 4'd2,
    S_DEC       = 4'd3,
    S_BR3       = 4'd4,
    S_BR4       = 4'd5,
    S_BR5       = 4'd6,
    S_BR6       = 4'd7,
    S_JR3       = 4'd8,
    S_JAL3      = 4'd9,
    S_JAL4      = 4'd10,
    S_EXEC_WAIT = 4'd11,
    S_HALT      = 4'd12
  } state_t;

  state_t     state, state_next;
  logic       con_q;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign state_dbg = state;

  // State register; reset overrides every state including HALT and EXEC_WAIT
  always_ff @(posedge clk) begin
    if (reset) state <= S_T0;
    else       state <= state_next;
  end

  // CON is stable from BR4 on; sampling it at the end of BR5 keeps the BR6
  // PCin gate a function of registered state only
  always_ff @(posedge clk) begin
    if (reset)               con_q <= 1'b0;
    else if (state == S_BR5) con_q <= CON;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      S_T0:        state_next = stop ? S_HALT : S_T1;
      S_T1:        state_next = mem_ready ? S_T2 : S_T1;
      S_T2:        state_next = S_DEC;
      S_DEC: begin
        if      (opcode == OP_BR)   state_next = S_BR3;
        else if (opcode == OP_JR)   state_next = S_JR3;
        else if (opcode == OP_JAL)  state_next = S_JAL3;
        else if (opcode == OP_NOP)  state_next = S_T0;
        else if (opcode == OP_HALT) state_next = S_HALT;
        else                        state_next = S_EXEC_WAIT;
      end
      S_BR3:       state_next = S_BR4;
      S_BR4:       state_next = S_BR5;
      S_BR5:       state_next = S_BR6;
      S_BR6:       state_next = S_T0;
      S_JR3:       state_next = S_T0;
      S_JAL3:      state_next = S_JAL4;
      S_JAL4:      state_next = S_T0;
      S_EXEC_WAIT: state_next = exec_done ? S_T0 : S_EXEC_WAIT;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_T0;
    endcase
  end

  // Moore output decode from the registered state
  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    Cout     = 1'b0;
    Rout     = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    CONin    = 1'b0;
    LinkIn   = 1'b0;
    IncPC    = 1'b0;
    ADD      = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    exec_req = 1'b0;
    run      = 1'b1;
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_BR3: begin
        Gra   = 1'b1;
        Rout  = 1'b1;
        CONin = 1'b1;
      end
      S_BR4: begin
        PCout = 1'b1;
        Yin   = 1'b1;
      end
      S_BR5: begin
        Cout = 1'b1;
        ADD  = 1'b1;
        Zin  = 1'b1;
      end
      S_BR6: begin
        Zlowout = 1'b1;
        PCin    = con_q;
      end
      S_JR3, S_JAL4: begin
        Gra  = 1'b1;
        Rout = 1'b1;
        PCin = 1'b1;
      end
      S_JAL3: begin
        PCout  = 1'b1;
        LinkIn = 1'b1;
      end
      S_EXEC_WAIT: exec_req = 1'b1;
      S_HALT:      run = 1'b0;
      default: ;
    endcase
  end

endmodule
